// File: rtl/mips32_prog_loader.sv
// Program loader and result dumper for the MIPS32 core: streams words into
// instruction memory, holds the core until loading ends, then dumps registers.
module mips32_prog_loader #(
   parameter int         ADDR_W      = 10,
   parameter int         DUMP_REGS   = 6,
   parameter logic [5:0] HLT_OPCODE  = 6'h3f,
   parameter int         RUN_TIMEOUT = 1024
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_run,
   input  logic              core_halted,
   output logic [4:0]        rf_rd_addr,
   input  logic [31:0]       rf_rd_data,
   output logic              dump_valid,
   output logic [4:0]        dump_reg,
   output logic [31:0]       dump_data,
   output logic              done,
   output logic              err_overflow,
   output logic              err_timeout
);

   localparam int                TW    = $clog2(RUN_TIMEOUT);
   localparam logic [TW-1:0]     TLAST = TW'(RUN_TIMEOUT - 1);
   localparam logic [4:0]        ILAST = 5'(DUMP_REGS - 1);
   localparam logic [ADDR_W-1:0] WLAST = '1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DUMP, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_wcnt;
   logic [TW-1:0]     r_tcnt;
   logic [4:0]        r_idx;
   logic              r_memWe;
   logic [ADDR_W-1:0] r_memAddr;
   logic [31:0]       r_memWdata;
   logic              r_dumpValid;
   logic [4:0]        r_dumpReg;
   logic [31:0]       r_dumpData;
   logic              r_errOverflow;
   logic              r_errTimeout;

   logic w_beat;
   logic w_isHlt;
   logic w_start;
   logic w_halt;
   logic w_timeout;

   assign w_beat    = in_valid && (r_state == S_LOAD);
   assign w_isHlt   = (in_data[31:26] == HLT_OPCODE);
   assign w_start   = load_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   // The core is still leaving its hold state in the first RUN cycle, so its
   // HALTED flag is not trusted until tcnt has moved off zero.
   assign w_halt    = (r_state == S_RUN) && core_halted && (r_tcnt != '0);
   assign w_timeout = (r_state == S_RUN) && (r_tcnt == TLAST) && !w_halt;

   always_ff @(posedge clk1) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      in_ready   = 1'b0;
      core_run   = 1'b0;
      done       = 1'b0;
      rf_rd_addr = '0;
      case (r_state)
         S_IDLE: if (load_start) w_next = S_LOAD;
         S_LOAD: begin
            in_ready = 1'b1;
            if (w_beat && w_isHlt)                  w_next = S_RUN;
            else if (w_beat && (r_wcnt == WLAST))   w_next = S_DONE;
         end
         S_RUN: begin
            core_run = 1'b1;
            if (w_halt)         w_next = S_DUMP;
            else if (w_timeout) w_next = S_DONE;
         end
         S_DUMP: begin
            rf_rd_addr = r_idx;
            if (r_idx == ILAST) w_next = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (load_start) w_next = S_LOAD;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         r_wcnt        <= '0;
         r_tcnt        <= '0;
         r_idx         <= '0;
         r_memWe       <= 1'b0;
         r_memAddr     <= '0;
         r_memWdata    <= '0;
         r_dumpValid   <= 1'b0;
         r_dumpReg     <= '0;
         r_dumpData    <= '0;
         r_errOverflow <= 1'b0;
         r_errTimeout  <= 1'b0;
      end else begin
         r_memWe <= w_beat;
         if (w_beat) begin
            r_memAddr  <= r_wcnt;
            r_memWdata <= in_data;
            r_wcnt     <= r_wcnt + 1'b1;
         end
         if (w_start) begin
            r_wcnt        <= '0;
            r_errOverflow <= 1'b0;
            r_errTimeout  <= 1'b0;
         end
         if (w_beat && !w_isHlt && (r_wcnt == WLAST)) r_errOverflow <= 1'b1;
         if (w_timeout) r_errTimeout <= 1'b1;
         r_tcnt <= (r_state == S_RUN) ? r_tcnt + 1'b1 : '0;
         // Register read is combinational, so each dump beat lags its address by one cycle.
         r_dumpValid <= (r_state == S_DUMP);
         if (r_state == S_DUMP) begin
            r_dumpReg  <= r_idx;
            r_dumpData <= rf_rd_data;
         end
         r_idx <= ((r_state == S_DUMP) && (r_idx != ILAST)) ? r_idx + 5'd1 : '0;
      end
   end

   assign mem_we       = r_memWe;
   assign mem_addr     = r_memAddr;
   assign mem_wdata    = r_memWdata;
   assign dump_valid   = r_dumpValid;
   assign dump_reg     = r_dumpReg;
   assign dump_data    = r_dumpData;
   assign err_overflow = r_errOverflow;
   assign err_timeout  = r_errTimeout;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: plays the core and register file, and checks
// memory writes, run length, dump stream and flags against a program-level model.
module tb_mips32_prog_loader;

   localparam int AW   = 4;
   localparam int NREG = 6;
   localparam int RTO  = 16;
   localparam int MEMW = 1 << AW;

   typedef logic [31:0][31:0] rfVec_t;
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;
   typedef struct packed {
      logic [31:0] cyc;
      logic [4:0]  regIdx;
      logic [31:0] data;
   } dump_t;

   logic          clk1 = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_start = 1'b0;
   logic          in_valid = 1'b0;
   logic [31:0]   in_data = '0;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          core_run;
   logic          core_halted = 1'b0;
   logic [4:0]    rf_rd_addr;
   logic [31:0]   rf_rd_data;
   logic          dump_valid;
   logic [4:0]    dump_reg;
   logic [31:0]   dump_data;
   logic          done;
   logic          err_overflow;
   logic          err_timeout;

   rfVec_t        coreRf = '0;
   logic [31:0]   coreMem [MEMW];
   wr_t           wrLog[$];
   dump_t         dumpLog[$];
   int            runCnt = 0;
   logic [31:0]   cyc = '0;
   int            vectors = 0;
   int            miscompares = 0;
   logic [84:0]   outsVec;

   assign rf_rd_data = coreRf[rf_rd_addr];
   assign outsVec = {in_ready, mem_we, mem_addr, mem_wdata, core_run, rf_rd_addr,
                     dump_valid, dump_reg, dump_data, done, err_overflow, err_timeout};

   mips32_prog_loader #(
      .ADDR_W(AW), .DUMP_REGS(NREG), .HLT_OPCODE(6'h3f), .RUN_TIMEOUT(RTO)
   ) dut (
      .clk1(clk1), .rst_n(rst_n), .load_start(load_start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .core_run(core_run), .core_halted(core_halted),
      .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
      .dump_valid(dump_valid), .dump_reg(dump_reg), .dump_data(dump_data),
      .done(done), .err_overflow(err_overflow), .err_timeout(err_timeout)
   );

   // Free-running clock and a cycle stamp that only moves on the active edge.
   always #5 clk1 = ~clk1;
   always @(posedge clk1) cyc <= cyc + 1;

   // Passive monitor: log every memory write, dump beat and cycle with the core released.
   always @(negedge clk1) begin
      if (mem_we) begin
         wrLog.push_back('{addr: mem_addr, data: mem_wdata});
         coreMem[mem_addr] = mem_wdata;
      end
      if (dump_valid) dumpLog.push_back('{cyc: cyc, regIdx: dump_reg, data: dump_data});
      if (core_run) runCnt <= runCnt + 1;
   end

   // Program-level model of the core: ADDI and ADD until the HLT word.
   function automatic rfVec_t execute(input logic [31:0] prog[$]);
      rfVec_t r = '0;
      for (int i = 0; i < prog.size(); i++) begin
         logic [31:0] w = prog[i];
         if (w[31:26] == 6'h3f) break;
         if (w[31:26] == 6'h0a && w[20:16] != 0)
            r[w[20:16]] = r[w[25:21]] + {{16{w[15]}}, w[15:0]};
         else if (w[31:26] == 6'h00 && w[15:11] != 0)
            r[w[15:11]] = r[w[25:21]] + r[w[20:16]];
      end
      return r;
   endfunction

   function automatic logic [31:0] randWord();
      logic [4:0] rs = 5'($urandom_range(0, 5));
      logic [4:0] rt = 5'($urandom_range(1, 5));
      logic [4:0] rd = 5'($urandom_range(1, 5));
      if ($urandom_range(0, 1) == 1) return {6'h0a, rs, rt, 16'($urandom)};
      return {6'h00, rs, rt, rd, 5'd0, 6'h20};
   endfunction

   // Every comparison goes through here so the counters stay honest.
   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Request a new load and confirm the previous run's flags are gone.
   task automatic pulseStart(input string name);
      @(negedge clk1);
      load_start = 1'b1;
      @(negedge clk1);
      load_start = 1'b0;
      checkOutput({name, " in_ready after start"}, in_ready, 1);
      checkOutput({name, " flags cleared"}, {done, err_overflow, err_timeout}, 0);
   endtask

   // Stream words until all are taken or the loader stops accepting.
   task automatic applyStimulus(input logic [31:0] prog[$], input int mode, output logic readyAfter);
      int i = 0;
      int guard = 0;
      bit broke = 0;
      while (i < prog.size() && guard < 300 && !broke) begin
         @(negedge clk1);
         guard++;
         if (i > 0 && !in_ready) broke = 1;
         else if ((mode == 1 && guard % 2 == 0) || (mode == 2 && $urandom_range(0, 1) == 0))
            in_valid = 1'b0;
         else begin
            in_valid = 1'b1;
            in_data  = prog[i];
            if (in_ready) i++;
         end
      end
      if (!broke) begin
         @(negedge clk1);
         in_valid = 1'b1;
         in_data  = 32'hdead_beef;
      end
      readyAfter = in_ready;
   endtask

   // One complete load/run/dump sequence; d<0 means the core never halts.
   task automatic runScenario(input string name, input logic [31:0] prog[$], input int mode,
                              input int d, input bit misc);
      int hltIdx = -1;
      bit expOvf, expTo;
      int expW, expRun, expDumps, wS, dS, rS, g;
      logic [31:0] haltCyc = '0;
      logic [31:0] memQ[$];
      logic rdy;
      rfVec_t expRf;
      for (int i = 0; i < prog.size(); i++)
         if (hltIdx < 0 && prog[i][31:26] == 6'h3f) hltIdx = i;
      expOvf   = (hltIdx < 0 || hltIdx >= MEMW);
      expTo    = !expOvf && d < 0;
      expW     = expOvf ? MEMW : hltIdx + 1;
      expRun   = expOvf ? 0 : (d < 0 ? RTO : (d == 0 ? 2 : d + 1));
      expDumps = (!expOvf && d >= 0) ? NREG : 0;
      expRf    = execute(prog);
      wS = wrLog.size();
      dS = dumpLog.size();
      rS = runCnt;
      core_halted = 1'b0;
      pulseStart(name);
      applyStimulus(prog, mode, rdy);
      checkOutput({name, " in_ready after last word"}, rdy, 0);
      g = 0;
      while (!core_run && g < 4) begin
         @(negedge clk1);
         g++;
      end
      if (core_run) begin
         #1;
         for (int a = 0; a < MEMW; a++) memQ.push_back(coreMem[a]);
         coreRf = execute(memQ);
         if (d >= 0) begin
            if (misc) begin
               load_start = 1'b1;
               @(negedge clk1);
               load_start = 1'b0;
               repeat (d - 1) @(negedge clk1);
            end else begin
               repeat (d) @(negedge clk1);
            end
            core_halted = 1'b1;
            haltCyc = cyc + ((d == 0) ? 1 : 0);
            if (misc) begin
               @(negedge clk1);
               load_start = 1'b1;
               @(negedge clk1);
               load_start = 1'b0;
            end
         end
      end
      g = 0;
      while (!done && g < 60) begin
         @(negedge clk1);
         g++;
      end
      checkOutput({name, " done"}, done, 1);
      repeat (2) @(negedge clk1);
      in_valid = 1'b0;
      checkOutput({name, " write count"}, wrLog.size() - wS, expW);
      for (int i = 0; i < expW; i++)
         if (wS + i < wrLog.size())
            checkOutput($sformatf("%s write %0d", name, i),
                        {wrLog[wS + i].addr, wrLog[wS + i].data}, {AW'(i), prog[i]});
      checkOutput({name, " core_run cycles"}, runCnt - rS, expRun);
      checkOutput({name, " dump count"}, dumpLog.size() - dS, expDumps);
      for (int k = 0; k < expDumps; k++)
         if (dS + k < dumpLog.size())
            checkOutput($sformatf("%s dump R%0d", name, k),
                        {dumpLog[dS + k].cyc, dumpLog[dS + k].regIdx, dumpLog[dS + k].data},
                        {haltCyc + 32'(2 + k), 5'(k), expRf[k]});
      checkOutput({name, " end flags"}, {done, err_overflow, err_timeout, core_run, in_ready},
                  {1'b1, expOvf, expTo, 2'b00});
   endtask

   initial begin
      logic [31:0] sumProg[$] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                                  32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                                  32'hfc000000};
      logic [31:0] p[$];
      logic rdy;
      int wS;

      repeat (3) @(negedge clk1);
      checkOutput("reset outputs", outsVec, 0);
      rst_n = 1'b1;

      runScenario("sum", sumProg, 0, 5, 0);
      runScenario("sum-bubbles", sumProg, 1, 3, 1);

      p.delete();
      for (int i = 0; i <= MEMW; i++) p.push_back(randWord());
      runScenario("overflow", p, 0, 4, 0);

      p.delete();
      for (int i = 0; i < MEMW - 1; i++) p.push_back(randWord());
      p.push_back({6'h3f, 26'($urandom)});
      runScenario("hlt-last-slot", p, 2, RTO - 1, 0);

      runScenario("timeout", sumProg, 0, -1, 0);
      runScenario("halt-first-cycle", sumProg, 0, 0, 0);

      wS = wrLog.size();
      pulseStart("reset-mid");
      p = sumProg[0:2];
      applyStimulus(p, 0, rdy);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk1);
      checkOutput("reset-mid outputs", outsVec, 0);
      repeat (3) @(negedge clk1);
      checkOutput("reset-mid outputs held", outsVec, 0);
      checkOutput("reset-mid write count", wrLog.size() - wS, 3);
      rst_n = 1'b1;
      runScenario("sum-after-reset", sumProg, 0, 7, 0);

      for (int n = 0; n < 8; n++) begin
         p.delete();
         for (int i = 0; i < int'($urandom_range(1, MEMW - 2)); i++) p.push_back(randWord());
         p.push_back({6'h3f, 26'($urandom)});
         runScenario($sformatf("random%0d", n), p, int'($urandom_range(0, 2)),
                     (n == 5) ? -1 : int'($urandom_range(0, RTO - 1)), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
